// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone burst master: cycle-type encodings and FSM states.
package wb_master_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_t;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Ack watchdog for wb_burst_master: flags a stalled strobe after TIMEOUT_CYC cycles.
// Only built when WB_MASTER_TIMEOUT_EN is defined.
`ifdef WB_MASTER_TIMEOUT_EN
module wb_ack_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic ack,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // Counts consecutive strobe cycles without a qualifying ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!stb || ack) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = stb & ~ack & (cnt == CW'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/wb_burst_master.sv
// Wishbone B3 initiator issuing single or incrementing-burst reads/writes from a command port.
// Optional ack watchdog with abort reporting is enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int dw          = 32,
    parameter int APP_AW      = 26,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              init_done_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [APP_AW-1:0] cmd_addr_i,
    input  logic [3:0]        cmd_len_i,
    input  logic              wdat_valid_i,
    input  logic [dw-1:0]     wdat_i,
    input  logic [dw/8-1:0]   wdat_sel_i,
    output logic              wdat_ready_o,
    output logic              rdat_valid_o,
    output logic [dw-1:0]     rdat_o,
    output logic              done_o,
    output logic              err_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [dw-1:0]     wb_dat_i
);

    state_t            state;
    state_t            state_nxt;
    logic              we_q;
    logic              burst_q;
    logic [APP_AW-1:0] addr_q;
    logic [3:0]        cnt_q;
    logic              in_bus;
    logic              stb_int;
    logic              beat;
    logic              accept;
    logic              timeout_hit;

    assign in_bus      = (state == BUS);
    assign stb_int     = in_bus & (we_q ? wdat_valid_i : 1'b1);
    assign beat        = stb_int & wb_ack_i;
    assign cmd_ready_o = (state == IDLE) & init_done_i & wb_rst_n;
    assign accept      = cmd_valid_i & cmd_ready_o;

`ifdef WB_MASTER_TIMEOUT_EN
    logic err_q;

    wb_ack_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n),
        .stb     (stb_int),
        .ack     (beat),
        .timeout (timeout_hit)
    );

    // Remembers that the command ended by abort so err_o lines up with done_o.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign err_o = (state == DONE) & err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            burst_q      <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            rdat_o       <= '0;
            rdat_valid_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            rdat_valid_o <= beat & ~we_q;
            if (beat && !we_q) begin
                rdat_o <= wb_dat_i;
            end
            if (accept) begin
                we_q    <= cmd_we_i;
                burst_q <= (cmd_len_i != 4'd0);
                addr_q  <= cmd_addr_i;
                cnt_q   <= cmd_len_i;
            end else if (beat) begin
                // Address wraps silently at the top of the byte-address space.
                addr_q <= addr_q + APP_AW'(dw / 8);
                cnt_q  <= cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wdat_ready_o = 1'b0;
        done_o       = 1'b0;
        wb_cyc_o     = 1'b0;
        wb_stb_o     = 1'b0;
        wb_we_o      = 1'b0;
        wb_addr_o    = '0;
        wb_dat_o     = '0;
        wb_sel_o     = '0;
        wb_cti_o     = CTI_CLASSIC;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                wb_cyc_o     = 1'b1;
                wb_stb_o     = stb_int;
                wb_we_o      = we_q;
                wb_addr_o    = addr_q;
                wb_dat_o     = we_q ? wdat_i : '0;
                wb_sel_o     = we_q ? wdat_sel_i : '1;
                wb_cti_o     = !burst_q ? CTI_CLASSIC :
                               (cnt_q == 4'd0) ? CTI_EOB : CTI_INCR;
                wdat_ready_o = beat & we_q;
                if ((beat && cnt_q == 4'd0) || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
